// File: rtl/ahb_bus_arbiter_pkg.sv
// Shared types, HTRANS encodings and burst-length helper for the AHB bus arbiter.
// ARB_LOCKED exists only when AHB_ARB_LOCK_EN is defined.
package ahb_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_BURST  = 2'd1,
      ARB_UNDEF  = 2'd2
`ifdef AHB_ARB_LOCK_EN
      , ARB_LOCKED = 2'd3
`endif
   } arbState_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;

   // Beats in a burst; INCR has no defined length and returns 0.
   function automatic logic [4:0] burstBeats(input logic [2:0] hburst);
      logic [4:0] beats;
      case (hburst)
         3'b000:          beats = 5'd1;
         3'b010, 3'b011:  beats = 5'd4;
         3'b100, 3'b101:  beats = 5'd8;
         3'b110, 3'b111:  beats = 5'd16;
         default:         beats = 5'd0;
      endcase
      return beats;
   endfunction

endpackage

// File: rtl/ahb_arb_rr_picker.sv
// Combinational round-robin search: first requester after last_idx, wrapping,
// with last_idx itself considered last so a lone owner keeps the bus.
module ahb_arb_rr_picker #(
   parameter int NUM_MANAGERS = 4,
   parameter int IDX_WIDTH    = 4
) (
   input  logic [NUM_MANAGERS-1:0] req,
   input  logic [IDX_WIDTH-1:0]    last_idx,
   output logic [NUM_MANAGERS-1:0] grant,
   output logic                    valid
);

   always_comb begin
      int pos;
      grant = '0;
      valid = 1'b0;
      pos   = 0;
      for (int i = 1; i <= NUM_MANAGERS; i++) begin
         pos = int'(last_idx) + i;
         if (pos >= NUM_MANAGERS) pos = pos - NUM_MANAGERS;
         for (int j = 0; j < NUM_MANAGERS; j++) begin
            if (!valid && (pos == j) && req[j]) begin
               grant[j] = 1'b1;
               valid    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// Multi-manager AHB arbiter: round-robin ownership with burst/undefined-length
// protection; locked sequences are honoured only when AHB_ARB_LOCK_EN is defined.
module ahb_bus_arbiter
   import ahb_bus_arbiter_pkg::*;
#(
   parameter int NUM_MANAGERS    = 4,
   parameter int DEFAULT_MANAGER = 0,
   parameter int HMASTER_WIDTH   = 4
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic [NUM_MANAGERS-1:0]  hbusreq,
   input  logic [NUM_MANAGERS-1:0]  hlock,
   input  logic [1:0]               HTRANS,
   input  logic [2:0]               HBURST,
   input  logic                     HREADY,
   input  logic                     HRESP,
   output logic [NUM_MANAGERS-1:0]  hgrant,
   output logic [HMASTER_WIDTH-1:0] HMASTER,
   output logic                     HMASTLOCK,
   output logic [HMASTER_WIDTH-1:0] dataOwner
);

   localparam logic [NUM_MANAGERS-1:0]  DEF_GRANT = NUM_MANAGERS'(1) << DEFAULT_MANAGER;
   localparam logic [HMASTER_WIDTH-1:0] DEF_IDX   = HMASTER_WIDTH'(DEFAULT_MANAGER);

   arbState_e                 state_q, state_d;
   logic [4:0]                beat_cnt_q, beat_cnt_d;
   logic [NUM_MANAGERS-1:0]   hgrant_q, hgrant_d;
   logic [HMASTER_WIDTH-1:0]  hmaster_q, hmaster_d;
   logic [HMASTER_WIDTH-1:0]  data_owner_q, data_owner_d;
   logic                      err_pend_q, err_pend_d;

   logic [NUM_MANAGERS-1:0]   win_grant;
   logic                      win_valid;
   logic [HMASTER_WIDTH-1:0]  win_idx;
   logic                      own_req;
   logic                      err;
   logic                      nonseq_acc;
   logic                      seq_acc;
   logic                      arb_pt;
   logic [4:0]                load_beats;

   ahb_arb_rr_picker #(
      .NUM_MANAGERS (NUM_MANAGERS),
      .IDX_WIDTH    (HMASTER_WIDTH)
   ) u_picker (
      .req      (hbusreq),
      .last_idx (hmaster_q),
      .grant    (win_grant),
      .valid    (win_valid)
   );

`ifdef AHB_ARB_LOCK_EN
   logic own_lock;
   logic hmastlock_q, hmastlock_d;
`else
   logic unused_hlock;
   assign unused_hlock = ^hlock;
`endif

   // Owner-side request/lock and winner index decoded from one-hot vectors.
   always_comb begin
      own_req = 1'b0;
`ifdef AHB_ARB_LOCK_EN
      own_lock = 1'b0;
`endif
      win_idx = DEF_IDX;
      for (int i = 0; i < NUM_MANAGERS; i++) begin
         if (hgrant_q[i]) begin
            own_req = hbusreq[i];
`ifdef AHB_ARB_LOCK_EN
            own_lock = hlock[i];
`endif
         end
         if (win_grant[i]) win_idx = HMASTER_WIDTH'(i);
      end
   end

   always_comb begin
      err        = HRESP | err_pend_q;
      nonseq_acc = HREADY && (HTRANS == HTRANS_NONSEQ);
      seq_acc    = HREADY && (HTRANS == HTRANS_SEQ);
      load_beats = burstBeats(HBURST);

      arb_pt = 1'b0;
      if (HREADY) begin
         if (err) begin
            arb_pt = 1'b1;
         end else begin
            case (state_q)
               ARB_IDLE:   arb_pt = 1'b1;
               ARB_BURST:  arb_pt = seq_acc && (beat_cnt_q == 5'd1);
               ARB_UNDEF:  arb_pt = !own_req;
`ifdef AHB_ARB_LOCK_EN
               ARB_LOCKED: arb_pt = !own_lock && (HTRANS == HTRANS_IDLE);
`endif
               default:    arb_pt = 1'b1;
            endcase
         end
      end

      state_d      = state_q;
      hgrant_d     = hgrant_q;
      hmaster_d    = hmaster_q;
      err_pend_d   = HREADY ? 1'b0 : err;
      data_owner_d = HREADY ? hmaster_q : data_owner_q;

      // The NONSEQ beat itself is counted, hence load minus one.
      beat_cnt_d = beat_cnt_q;
      if (nonseq_acc)
         beat_cnt_d = (load_beats == 5'd0) ? 5'd0 : load_beats - 5'd1;
      else if (seq_acc && (beat_cnt_q != 5'd0))
         beat_cnt_d = beat_cnt_q - 5'd1;
      if (err) beat_cnt_d = 5'd0;

      if (arb_pt) begin
`ifdef AHB_ARB_LOCK_EN
         if (own_lock) state_d = ARB_LOCKED;
         else
`endif
         if (!err && nonseq_acc && (HBURST != HBURST_SINGLE)) begin
            state_d = (HBURST == HBURST_INCR) ? ARB_UNDEF : ARB_BURST;
         end else begin
            state_d   = ARB_IDLE;
            hgrant_d  = win_valid ? win_grant : DEF_GRANT;
            hmaster_d = win_idx;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q      <= ARB_IDLE;
         beat_cnt_q   <= 5'd0;
         hgrant_q     <= DEF_GRANT;
         hmaster_q    <= DEF_IDX;
         data_owner_q <= DEF_IDX;
         err_pend_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         beat_cnt_q   <= beat_cnt_d;
         hgrant_q     <= hgrant_d;
         hmaster_q    <= hmaster_d;
         data_owner_q <= data_owner_d;
         err_pend_q   <= err_pend_d;
      end
   end

`ifdef AHB_ARB_LOCK_EN
   assign hmastlock_d = (state_d == ARB_LOCKED);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) hmastlock_q <= 1'b0;
      else          hmastlock_q <= hmastlock_d;
   end

   assign HMASTLOCK = hmastlock_q;
`else
   assign HMASTLOCK = 1'b0;
`endif

   assign hgrant    = hgrant_q;
   assign HMASTER   = hmaster_q;
   assign dataOwner = data_owner_q;

endmodule

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Multi-manager arbiter for the shared AHB bus in the AHB AVIP HDL top. Each manager raises a bus request. The arbiter picks exactly one bus owner, drives `HMASTER` and the address/data-phase mux selects, and protects fixed-length bursts and locked sequences from re-arbitration. It sits between the manager agents and the `HADDR`/`HWDATA` multiplexers feeding the shared interface.

## Interface
- `NUM_MANAGERS`, 4 — number of requesting managers (2–16).
- `DEFAULT_MANAGER`, 0 — parking owner when nothing requests.
- `HMASTER_WIDTH`, 4 — width of `HMASTER`; must satisfy 2^`HMASTER_WIDTH` ≥ `NUM_MANAGERS`.

Ports (name, direction, width, meaning):
- `HCLK` in 1 — bus clock.
- `HRESETn` in 1 — asynchronous, active-low reset.
- `hbusreq` in `NUM_MANAGERS` — per-manager request.
- `hlock` in `NUM_MANAGERS` — per-manager lock request.
- `HTRANS` in 2 — transfer type from the current address-phase owner.
- `HBURST` in 3 — burst type from the current owner.
- `HREADY` in 1 — combined ready.
- `HRESP` in 1 — response; 1 = ERROR.
- `hgrant` out `NUM_MANAGERS` — one-hot address-phase grant.
- `HMASTER` out `HMASTER_WIDTH` — index of the address-phase owner.
- `HMASTLOCK` out 1 — current transfer belongs to a locked sequence.
- `dataOwner` out `HMASTER_WIDTH` — index of the data-phase owner; `HWDATA` mux select.

## Operation
- States:
  - `ARB_IDLE`: no protected transfer; re-arbitration is allowed.
  - `ARB_BURST`: fixed-length burst in progress.
  - `ARB_UNDEF`: `INCR` burst of undefined length in progress.
  - `ARB_LOCKED`: locked sequence in progress.
- Beat counter (5 bits) is loaded when the owner issues NONSEQ with `HREADY`=1. Load value: SINGLE=1, INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16.
- The counter decrements on each accepted NONSEQ/SEQ beat. BUSY and IDLE do not decrement it.
- Transitions:
  - NONSEQ with a fixed burst other than SINGLE → `ARB_BURST`.
  - NONSEQ INCR → `ARB_UNDEF`.
  - Owner's `hlock` high at an arbitration point → `ARB_LOCKED`.
- Arbitration point: a cycle with `HREADY`=1 and any of the following:
  - state `ARB_IDLE`;
  - `ARB_BURST` with the last beat accepted (counter 1→0);
  - `ARB_UNDEF` with the owner's `hbusreq` low;
  - `ARB_LOCKED` with the owner's `hlock` low and `HTRANS`=IDLE.
- `HRESP`=1 in any state forces the next `HREADY`=1 cycle to be an arbitration point (burst aborted); the counter is cleared.
- Selection is round-robin: search starts at owner+1 and wraps modulo `NUM_MANAGERS`. If no request is pending, park on `DEFAULT_MANAGER`.
- Owner still requesting with no other requester → owner retains the grant.
- `HMASTLOCK` = 1 while in `ARB_LOCKED`.
- Reset mid-burst: all state is discarded immediately and the reset values below apply.

## Timing
- `hgrant`, `HMASTER` and `HMASTLOCK` are registered and update on the `HCLK` edge ending an arbitration point. The new owner drives its address phase in the following cycle.
- `dataOwner` loads `HMASTER` on every edge with `HREADY`=1. It holds during wait states.
- Request-to-grant latency with an idle bus is 1 cycle. Worst case is 16 beats plus wait states, plus one round-robin rotation.
- Reset values:
  - `hgrant` = one-hot(`DEFAULT_MANAGER`);
  - `HMASTER` = `dataOwner` = `DEFAULT_MANAGER`;
  - `HMASTLOCK` = 0;
  - state `ARB_IDLE`; counter 0.
- `hgrant` is always exactly one-hot, including during reset.

## Configuration
- `AHB_ARB_LOCK_EN` defined: `hlock` honoured, `ARB_LOCKED` state present, `HMASTLOCK` driven as described.
- `AHB_ARB_LOCK_EN` undefined:
  - `hlock` is ignored;
  - `ARB_LOCKED` is removed;
  - `HMASTLOCK` is tied to 0;
  - all other behaviour is identical.

## Structure
- `AhbGlobalPackage` gains:
  - the `arbState_e` enum (`ARB_IDLE`, `ARB_BURST`, `ARB_UNDEF`, `ARB_LOCKED`);
  - a `burstBeats(HBURST)` function returning the load value (0 for INCR);
  - the HTRANS encodings IDLE/BUSY/NONSEQ/SEQ as constants.
- Sub-module `ahb_arb_rr_picker`: combinational round-robin search. Inputs are the request vector and the last owner index; outputs are the one-hot winner and a valid flag. All state stays in `ahb_bus_arbiter`.

## Test plan
- Reset release, no requests → `hgrant`=0001, `HMASTER`=0 (park); `hbusreq`=0100 → next edge `hgrant`=0100, `HMASTER`=2.
- Manager 1 INCR8 while manager 3 requests → `HMASTER` held at 1 for 8 accepted beats, including 2 inserted wait states; `HMASTER`=3 on the edge after beat 8.
- All four request continuously with SINGLE transfers → grants rotate 1,2,3,0,1 on consecutive `HREADY` cycles.
- Manager 0 INCR4, `HRESP`=1 on beat 2 → re-arbitration on the next `HREADY`=1 cycle; the counter reads 0.
- Manager 2 with `hlock`=1 for 3 SINGLE transfers while others request → `HMASTLOCK`=1 and `HMASTER`=2 throughout; release on `hlock`=0 with IDLE. With `AHB_ARB_LOCK_EN` undefined, arbitration rotates and `HMASTLOCK`=0.
- `HRESETn` asserted mid-INCR16 at beat 5 → outputs return to reset values immediately, asynchronously to `HCLK`.
